// File: rtl/spad_pkg.sv
// Shared FSM encodings and wrapped-address helper for the SPad read streamer.
// Pure definitions, no latency.
// No flow control here.
package spad_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Sum is truncated to sum_width bits, then folded back once into [0, depth).
  function automatic int unsigned wrap_add(input int unsigned base,
                                           input int unsigned idx,
                                           input int unsigned depth,
                                           input int unsigned sum_width);
    int unsigned sum;
    sum = (base + idx) & ((32'd1 << sum_width) - 32'd1);
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

endpackage

// File: rtl/spad_addr_gen.sv
// Window walker: latches base/length/passes, steps idx and pass counters, flags last/final.
// Address and flags are combinational from the current counters.
// Counters advance only when the parent issues a read.
module spad_addr_gen
  import spad_pkg::*;
#(
  parameter int DEPTH      = 96,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  length,
  input  logic [CNT_WIDTH-1:0]  passes,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  is_last,
  output logic                  is_final
);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [CNT_WIDTH-1:0]  passes_q;
  logic [CNT_WIDTH-1:0]  idx;
  logic [CNT_WIDTH-1:0]  pass_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      len_q    <= '0;
      passes_q <= '0;
      idx      <= '0;
      pass_cnt <= '0;
    end else if (load) begin
      base_q   <= base_addr;
      len_q    <= length;
      passes_q <= passes;
      idx      <= '0;
      pass_cnt <= '0;
    end else if (advance) begin
      if (is_last) begin
        idx      <= '0;
        pass_cnt <= pass_cnt + CNT_WIDTH'(1);
      end else begin
        idx <= idx + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    is_last  = (idx == len_q - CNT_WIDTH'(1));
    is_final = is_last && (pass_cnt == passes_q - CNT_WIDTH'(1));
    addr     = ADDR_WIDTH'(wrap_add(32'(base_q), 32'(idx), 32'(DEPTH), 32'(ADDR_WIDTH + 1)));
  end

endmodule

// File: rtl/spad_read_streamer.sv
// SPad reader: streams a (base, length) window 'passes' times; optional SPAD_STREAM_ZERO_FLAG_EN adds out_is_zero.
// Latency: start sampled -> first read next cycle -> out_valid the cycle after; 1 word/cycle.
// Backpressure: one-entry output register; no read issued while it is full and not consumed.
module spad_read_streamer
  import spad_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 96,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  length,
  input  logic [CNT_WIDTH-1:0]  passes,
  output logic                  busy,
  output logic                  done,
  output logic                  spad_chip_en,
  output logic [ADDR_WIDTH-1:0] spad_read_addr,
  input  logic [DATA_WIDTH-1:0] spad_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
`ifdef SPAD_STREAM_ZERO_FLAG_EN
  output logic                  out_is_zero,
`endif
  output logic                  out_last,
  output logic                  out_final
);

  logic [1:0]            state;
  logic                  accept;
  logic                  empty_cmd;
  logic                  rd_issue;
  logic                  handshake;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic                  gen_last;
  logic                  gen_final;
  logic [ADDR_WIDTH-1:0] addr_hold;

  spad_addr_gen #(
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .advance  (rd_issue),
    .base_addr(base_addr),
    .length   (length),
    .passes   (passes),
    .addr     (gen_addr),
    .is_last  (gen_last),
    .is_final (gen_final)
  );

  always_comb begin
    accept    = (state == ST_IDLE) && start;
    empty_cmd = (length == '0) || (passes == '0);
    handshake = out_valid && out_ready;
    // Refill the output register whenever it is empty or draining this cycle.
    rd_issue  = (state == ST_STREAM) && (!out_valid || out_ready);
    spad_chip_en   = rd_issue;
    spad_read_addr = rd_issue ? gen_addr : addr_hold;
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_final <= 1'b0;
      addr_hold <= '0;
    end else begin
      if (rd_issue) begin
        out_valid <= 1'b1;
        out_data  <= spad_read_data;
        out_last  <= gen_last;
        out_final <= gen_final;
        addr_hold <= gen_addr;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE:   if (start) state <= empty_cmd ? ST_DONE : ST_STREAM;
        ST_STREAM: if (rd_issue && gen_final) state <= ST_DRAIN;
        ST_DRAIN:  if (handshake && out_final) state <= ST_DONE;
        ST_DONE:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPAD_STREAM_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_is_zero <= 1'b0;
    end else if (rd_issue) begin
      out_is_zero <= (spad_read_data == '0);
    end
  end
`endif

endmodule
